// File: rtl/sramlike_arbiter_pkg.sv
// rtl/sramlike_arbiter_pkg.sv - shared encodings and grant policy for the sram-like arbiter
package sramlike_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2
  } arbStateT;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gntT;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } sizeT;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  // Data normally wins; inst only wins a tie when data was the previous grant.
  function automatic gntT pickGrant(input logic instReq, input logic dataReq, input gntT lastGnt);
    if (dataReq && !(instReq && lastGnt == GNT_D)) begin
      return GNT_D;
    end
    return GNT_I;
  endfunction

endpackage

// File: rtl/sramlike_arbiter_if.sv
// rtl/sramlike_arbiter_if.sv - inst, data and memory sram-like buses of the arbiter
interface sramlike_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              inst_req;
  logic              inst_wr;
  logic [1:0]        inst_size;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_wdata;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  logic              m_req;
  logic              m_wr;
  logic [1:0]        m_size;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_addr_ok;
  logic              m_data_ok;
  logic [DATA_W-1:0] m_rdata;

  // Arbiter side: answers the two requesters, drives the memory.
  modport slave (
    input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output m_req, m_wr, m_size, m_addr, m_wdata,
    input  m_addr_ok, m_data_ok, m_rdata
  );

  // Environment side: requesters and memory model.
  modport master (
    output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  m_req, m_wr, m_size, m_addr, m_wdata,
    output m_addr_ok, m_data_ok, m_rdata
  );

endinterface

// File: rtl/sramlike_arbiter_req_mux.sv
// rtl/sramlike_arbiter_req_mux.sv - selects the granted requester's request fields
module sramlike_req_mux
  import sramlike_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  gntT               gnt,
  input  logic              instReq,
  input  logic              instWr,
  input  logic [1:0]        instSize,
  input  logic [ADDR_W-1:0] instAddr,
  input  logic [DATA_W-1:0] instWdata,
  input  logic              dataReq,
  input  logic              dataWr,
  input  logic [1:0]        dataSize,
  input  logic [ADDR_W-1:0] dataAddr,
  input  logic [DATA_W-1:0] dataWdata,
  output logic              selReq,
  output logic              selWr,
  output logic [1:0]        selSize,
  output logic [ADDR_W-1:0] selAddr,
  output logic [DATA_W-1:0] selWdata
);

  logic pickData;

  assign pickData = (gnt == GNT_D);

  assign selReq   = pickData ? dataReq   : instReq;
  assign selWr    = pickData ? dataWr    : instWr;
  assign selSize  = pickData ? dataSize  : instSize;
  assign selAddr  = pickData ? dataAddr  : instAddr;
  assign selWdata = pickData ? dataWdata : instWdata;

endmodule

// File: rtl/sramlike_arbiter.sv
// rtl/sramlike_arbiter.sv - two-port sram-like arbiter with one outstanding memory transaction
module sramlike_arbiter
  import sramlike_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  sramlike_arbiter_if.slave   bus,
  output logic [31:0]         conflict_cnt
);

  arbStateT          state;
  arbStateT          nextState;
  gntT               lastGnt;
  gntT               nextGnt;
  logic              anyReq;
  logic              selReq;
  logic              selWr;
  logic [1:0]        selSize;
  logic [ADDR_W-1:0] selAddr;
  logic [DATA_W-1:0] selWdata;
  logic              active;
  logic              instServed;
  logic              dataServed;
  logic              contention;

  sramlike_req_mux #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) uReqMux (
    .gnt      (lastGnt),
    .instReq  (bus.inst_req),
    .instWr   (bus.inst_wr),
    .instSize (bus.inst_size),
    .instAddr (bus.inst_addr),
    .instWdata(bus.inst_wdata),
    .dataReq  (bus.data_req),
    .dataWr   (bus.data_wr),
    .dataSize (bus.data_size),
    .dataAddr (bus.data_addr),
    .dataWdata(bus.data_wdata),
    .selReq   (selReq),
    .selWr    (selWr),
    .selSize  (selSize),
    .selAddr  (selAddr),
    .selWdata (selWdata)
  );

  assign anyReq  = bus.inst_req || bus.data_req;
  assign nextGnt = pickGrant(bus.inst_req, bus.data_req, lastGnt);

  // lastGnt is loaded on every grant, so during ADDR/WAIT it is also the live grant.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      lastGnt <= GNT_I;
    end else begin
      state <= nextState;
      if (state == IDLE && anyReq) begin
        lastGnt <= nextGnt;
      end
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (anyReq) nextState = ADDR;
      end
      ADDR: begin
        if (!selReq) begin
          nextState = IDLE;
        end else if (bus.m_addr_ok) begin
          nextState = WAIT;
        end
      end
      WAIT: begin
        if (bus.m_data_ok) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Outputs are gated by resetn so they read 0 for the whole reset cycle.
  always_comb begin
    bus.m_req        = 1'b0;
    bus.m_wr         = 1'b0;
    bus.m_size       = 2'd0;
    bus.m_addr       = '0;
    bus.m_wdata      = '0;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    if (resetn) begin
      unique case (state)
        ADDR: begin
          if (selReq) begin
            bus.m_req   = 1'b1;
            bus.m_wr    = selWr;
            bus.m_size  = selSize;
            bus.m_addr  = selAddr;
            bus.m_wdata = selWdata;
            if (bus.m_addr_ok) begin
              if (lastGnt == GNT_D) bus.data_addr_ok = 1'b1;
              else                  bus.inst_addr_ok = 1'b1;
            end
          end
        end
        WAIT: begin
          if (bus.m_data_ok) begin
            if (lastGnt == GNT_D) bus.data_data_ok = 1'b1;
            else                  bus.inst_data_ok = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.inst_rdata = bus.m_rdata;
  assign bus.data_rdata = bus.m_rdata;

  assign active     = (state == ADDR) || (state == WAIT);
  assign instServed = active && (lastGnt == GNT_I);
  assign dataServed = active && (lastGnt == GNT_D);
  assign contention = bus.inst_req && bus.data_req && ((!instServed) ^ (!dataServed));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      conflict_cnt <= 32'd0;
    end else if (contention && conflict_cnt != CNT_MAX) begin
      conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_sramlike_arbiter.sv
// tb/tb_sramlike_arbiter.sv - directed self-checking bench for sramlike_arbiter
module tb_sramlike_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] conflictCnt;
  int          nAsserts = 0;
  int          nFail = 0;

  sramlike_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sramlike_arbiter #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .conflict_cnt(conflictCnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    bus.inst_req = 1'b0; bus.inst_wr = 1'b0; bus.inst_size = 2'd0;
    bus.inst_addr = 32'd0; bus.inst_wdata = 32'd0;
    bus.data_req = 1'b0; bus.data_wr = 1'b0; bus.data_size = 2'd0;
    bus.data_addr = 32'd0; bus.data_wdata = 32'd0;
    bus.m_addr_ok = 1'b0; bus.m_data_ok = 1'b0; bus.m_rdata = 32'd0;
  endtask

  task automatic chkQuiet(input string tag);
    chk({tag, "_mreq"}, bus.m_req, 0);
    chk({tag, "_mwr"}, bus.m_wr, 0);
    chk({tag, "_msize"}, bus.m_size, 0);
    chk({tag, "_maddr"}, bus.m_addr, 0);
    chk({tag, "_mwdata"}, bus.m_wdata, 0);
    chk({tag, "_iaok"}, bus.inst_addr_ok, 0);
    chk({tag, "_idok"}, bus.inst_data_ok, 0);
    chk({tag, "_daok"}, bus.data_addr_ok, 0);
    chk({tag, "_ddok"}, bus.data_data_ok, 0);
  endtask

  // One contended transaction with immediate addr_ok and data_ok; both requests held.
  task automatic serve(input logic expD, input logic [31:0] expCnt, input logic [31:0] rd);
    mid();
    chk("ctn_idle_mreq", bus.m_req, 0);
    chk("ctn_cnt", conflictCnt, expCnt);
    cyc();
    bus.m_addr_ok = 1'b1;
    mid();
    chk("ctn_mreq", bus.m_req, 1);
    chk("ctn_maddr", bus.m_addr, expD ? 32'h8000_0200 : 32'hBFC0_0100);
    chk("ctn_daok", bus.data_addr_ok, expD);
    chk("ctn_iaok", bus.inst_addr_ok, !expD);
    cyc();
    bus.m_addr_ok = 1'b0;
    bus.m_data_ok = 1'b1;
    bus.m_rdata = rd;
    mid();
    chk("ctn_ddok", bus.data_data_ok, expD);
    chk("ctn_idok", bus.inst_data_ok, !expD);
    chk("ctn_rdata", expD ? bus.data_rdata : bus.inst_rdata, rd);
    cyc();
    bus.m_data_ok = 1'b0;
  endtask

  initial begin
    clearInputs();
    resetn = 1'b0;

    // Reset state
    mid();
    chkQuiet("rst");
    cyc();
    mid();
    chk("rst_cnt", conflictCnt, 0);
    cyc();
    resetn = 1'b1;

    // Single inst read, stray m_data_ok in ADDR ignored
    bus.inst_req = 1'b1; bus.inst_size = 2'd2; bus.inst_addr = 32'hBFC0_0000;
    mid();
    chk("t1_c0_mreq", bus.m_req, 0);
    cyc();
    bus.m_data_ok = 1'b1;
    mid();
    chk("t1_c1_mreq", bus.m_req, 1);
    chk("t1_c1_maddr", bus.m_addr, 32'hBFC0_0000);
    chk("t1_c1_msize", bus.m_size, 2);
    chk("t1_c1_iaok", bus.inst_addr_ok, 0);
    chk("t1_c1_idok", bus.inst_data_ok, 0);
    cyc();
    bus.m_data_ok = 1'b0;
    bus.m_addr_ok = 1'b1;
    mid();
    chk("t1_c2_mreq", bus.m_req, 1);
    chk("t1_c2_iaok", bus.inst_addr_ok, 1);
    chk("t1_c2_daok", bus.data_addr_ok, 0);
    cyc();
    bus.m_addr_ok = 1'b0; bus.inst_req = 1'b0;
    mid();
    chk("t1_c3_mreq", bus.m_req, 0);
    chk("t1_c3_idok", bus.inst_data_ok, 0);
    cyc();
    bus.m_data_ok = 1'b1; bus.m_rdata = 32'h2408_0001;
    mid();
    chk("t1_c4_idok", bus.inst_data_ok, 1);
    chk("t1_c4_irdata", bus.inst_rdata, 32'h2408_0001);
    chk("t1_c4_ddok", bus.data_data_ok, 0);
    cyc();
    bus.m_data_ok = 1'b0;
    mid();
    chk("t1_c5_idok", bus.inst_data_ok, 0);
    chk("t1_c5_mreq", bus.m_req, 0);
    chk("t1_cnt", conflictCnt, 0);

    // Simultaneous inst/data right after reset: data first
    cyc();
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC0_0004;
    bus.data_req = 1'b1; bus.data_wr = 1'b1; bus.data_size = 2'd2;
    bus.data_addr = 32'h8000_0010; bus.data_wdata = 32'hCAFE_F00D;
    mid();
    chk("t2_c0_mreq", bus.m_req, 0);
    chk("t2_c0_cnt", conflictCnt, 0);
    cyc();
    mid();
    chk("t2_c1_mreq", bus.m_req, 1);
    chk("t2_c1_maddr", bus.m_addr, 32'h8000_0010);
    chk("t2_c1_mwr", bus.m_wr, 1);
    chk("t2_c1_mwdata", bus.m_wdata, 32'hCAFE_F00D);
    chk("t2_c1_daok", bus.data_addr_ok, 0);
    cyc();
    bus.m_addr_ok = 1'b1;
    mid();
    chk("t2_c2_daok", bus.data_addr_ok, 1);
    chk("t2_c2_iaok", bus.inst_addr_ok, 0);
    chk("t2_c2_cnt", conflictCnt, 1);
    cyc();
    bus.m_addr_ok = 1'b0; bus.data_req = 1'b0; bus.data_wr = 1'b0;
    bus.m_data_ok = 1'b1; bus.m_rdata = 32'h0;
    mid();
    chk("t2_c3_ddok", bus.data_data_ok, 1);
    chk("t2_c3_idok", bus.inst_data_ok, 0);
    chk("t2_c3_cnt", conflictCnt, 2);
    cyc();
    bus.m_data_ok = 1'b0;
    mid();
    chk("t2_c4_mreq", bus.m_req, 0);
    cyc();
    bus.m_addr_ok = 1'b1;
    mid();
    chk("t2_c5_maddr", bus.m_addr, 32'hBFC0_0004);
    chk("t2_c5_mwr", bus.m_wr, 0);
    chk("t2_c5_iaok", bus.inst_addr_ok, 1);
    cyc();
    bus.inst_req = 1'b0; bus.m_addr_ok = 1'b0;
    bus.m_data_ok = 1'b1; bus.m_rdata = 32'h1111_2222;
    mid();
    chk("t2_c6_idok", bus.inst_data_ok, 1);
    chk("t2_c6_irdata", bus.inst_rdata, 32'h1111_2222);
    chk("t2_c6_drdata", bus.data_rdata, 32'h1111_2222);
    cyc();
    bus.m_data_ok = 1'b0;

    // Sustained contention: D, I, D, I
    bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC0_0100;
    bus.data_req = 1'b1; bus.data_addr = 32'h8000_0200;
    serve(1'b1, 32'd2, 32'hA000_0001);
    serve(1'b0, 32'd4, 32'hA000_0002);
    serve(1'b1, 32'd6, 32'hA000_0003);
    serve(1'b0, 32'd8, 32'hA000_0004);

    // Data granted, drops req in ADDR before addr_ok; inst then granted
    mid();
    chk("t4_c0_cnt", conflictCnt, 10);
    cyc();
    mid();
    chk("t4_c1_maddr", bus.m_addr, 32'h8000_0200);
    cyc();
    bus.data_req = 1'b0;
    mid();
    chk("t4_c2_daok", bus.data_addr_ok, 0);
    chk("t4_c2_iaok", bus.inst_addr_ok, 0);
    cyc();
    mid();
    chk("t4_c3_mreq", bus.m_req, 0);
    cyc();
    bus.m_addr_ok = 1'b1;
    mid();
    chk("t4_c4_mreq", bus.m_req, 1);
    chk("t4_c4_maddr", bus.m_addr, 32'hBFC0_0100);
    chk("t4_c4_iaok", bus.inst_addr_ok, 1);
    cyc();
    bus.m_addr_ok = 1'b0; bus.inst_req = 1'b0;

    // Reset while in WAIT, then stray m_data_ok
    resetn = 1'b0;
    mid();
    chk("t5_pre_cnt", conflictCnt, 11);
    chkQuiet("t5_rst");
    cyc();
    mid();
    chk("t5_cnt", conflictCnt, 0);
    cyc();
    resetn = 1'b1;
    bus.m_data_ok = 1'b1; bus.m_rdata = 32'hDEAD_BEEF;
    mid();
    chkQuiet("t5_stray");
    chk("t5_stray_cnt", conflictCnt, 0);

    // Spurious m_data_ok in IDLE, then the FSM still starts a normal request
    cyc();
    mid();
    chk("t6_idok", bus.inst_data_ok, 0);
    chk("t6_ddok", bus.data_data_ok, 0);
    cyc();
    bus.m_data_ok = 1'b0;
    bus.inst_req = 1'b1; bus.inst_addr = 32'hBFC0_0200;
    mid();
    chk("t6_idle_mreq", bus.m_req, 0);
    cyc();
    bus.m_addr_ok = 1'b1;
    mid();
    chk("t6_mreq", bus.m_req, 1);
    chk("t6_maddr", bus.m_addr, 32'hBFC0_0200);
    chk("t6_iaok", bus.inst_addr_ok, 1);
    cyc();
    bus.m_addr_ok = 1'b0; bus.inst_req = 1'b0;
    bus.m_data_ok = 1'b1; bus.m_rdata = 32'h5555_AAAA;
    mid();
    chk("t6_idok2", bus.inst_data_ok, 1);
    chk("t6_irdata", bus.inst_rdata, 32'h5555_AAAA);
    cyc();
    bus.m_data_ok = 1'b0;
    mid();
    chkQuiet("t6_end");

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/sramlike_arbiter.md
SRAMLIKE_ARBITER -- requirements
Module: sramlike_arbiter

Interface
REQ-001 SHALL take parameter ADDR_W, default 32, address width.
REQ-002 SHALL take parameter DATA_W, default 32, data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-005 SHALL have inst port inst_req, inst_wr, inst_size[1:0], inst_addr[ADDR_W], inst_wdata[DATA_W] (inputs) and inst_addr_ok, inst_data_ok, inst_rdata[DATA_W] (outputs), sram-like protocol.
REQ-006 SHALL have data port with identical signals prefixed data_.
REQ-007 SHALL have memory port m_req, m_wr, m_size[1:0], m_addr, m_wdata (outputs) and m_addr_ok, m_data_ok, m_rdata (inputs).
REQ-008 SHALL have conflict_cnt, output, 32, saturating count of contention cycles.

Function
REQ-009 SHALL implement FSM states IDLE, ADDR, WAIT; at most one outstanding memory transaction.
REQ-010 IDLE: if any request is pending, SHALL register grant (GNT_I/GNT_D) and go to ADDR next cycle; m_req stays 0 in IDLE, so minimum req-to-m_req latency is 1 cycle.
REQ-011 Grant rule: data wins, except inst wins when both are pending and last_gnt==GNT_D; last_gnt updates on every grant.
REQ-012 ADDR: m_req=1; m_wr/m_size/m_addr/m_wdata SHALL be driven combinationally from the granted requester.
REQ-013 ADDR: on m_addr_ok=1, SHALL assert granted *_addr_ok in the same cycle and go to WAIT.
REQ-014 ADDR: if granted *_req drops before m_addr_ok, SHALL return to IDLE with no addr_ok issued.
REQ-015 WAIT: m_req=0; on m_data_ok=1, SHALL assert granted *_data_ok and route m_rdata to that requester's *_rdata in the same cycle, then go to IDLE.
REQ-016 Non-granted *_addr_ok/*_data_ok SHALL be 0 at all times; *_rdata of both ports SHALL equal m_rdata.
REQ-017 m_data_ok in IDLE or ADDR SHALL be ignored.
REQ-018 conflict_cnt SHALL increment each cycle in which inst_req and data_req are both 1 and exactly one of them is not being served (not in ADDR/WAIT for it); holds at 32'hFFFF_FFFF.
REQ-019 Back-to-back throughput: WAIT->IDLE->ADDR; a new transaction SHALL start 2 cycles after data_ok.

Reset
REQ-020 resetn=0 at a clock edge SHALL force state=IDLE, last_gnt=GNT_I, grant cleared, conflict_cnt=0.
REQ-021 During and after reset all outputs SHALL be 0: m_req, all *_addr_ok/*_data_ok, m_wr, m_size, m_addr, m_wdata.
REQ-022 Reset in ADDR/WAIT SHALL abandon the transaction; a later m_data_ok for it is ignored per REQ-017.

Structure
REQ-023 State encoding (IDLE=2'd0, ADDR=2'd1, WAIT=2'd2), grant encoding (GNT_I=1'b0, GNT_D=1'b1) and size codes (byte=0, half=1, word=2) SHALL be defined in a shared package/header.
REQ-024 Request-field selection SHALL be one sub-module, sramlike_req_mux, selecting between inst and data fields by grant; FSM and counter stay in the top module.

Verification
REQ-025 Single inst read: inst_req=1 with addr 32'hBFC0_0000; m_addr_ok at cycle 2, m_data_ok at cycle 4 with rdata 32'h2408_0001 -> m_req in cycles 1-2, inst_addr_ok at 2, inst_data_ok at 4 with rdata 32'h2408_0001, data_* acks 0.
REQ-026 Simultaneous inst/data after reset: data write addr 32'h8000_0010 -> data served first, inst second, conflict_cnt increments while inst waits.
REQ-027 Sustained contention over 4 transactions -> grants alternate D,I,D,I.
REQ-028 Granted requester drops req in ADDR before m_addr_ok -> return to IDLE, no addr_ok, next pending request granted.
REQ-029 resetn=0 in WAIT, then stray m_data_ok after reset -> no *_data_ok, all outputs 0, conflict_cnt=0.
REQ-030 Spurious m_data_ok in IDLE -> no *_data_ok, state unchanged.
